// File: rtl/gpio_test_monitor.sv
// End-of-test monitor: holds the DUT in reset, counts run cycles and
// watches the DUT GPIO output for a stable PASS/FAIL completion code.
// The verdict is pass, fail or timeout. It is reported with the cycle at
// which the qualifying code first appeared.
module gpio_test_monitor #(
    parameter int                     GPIO_WIDTH    = 8,
    parameter int                     COUNT_WIDTH   = 64,
    parameter int                     RESET_CYCLES  = 2,
    parameter logic [GPIO_WIDTH-1:0]  PASS_CODE     = '1,
    parameter logic [GPIO_WIDTH-1:0]  FAIL_CODE     = '0,
    parameter int                     STABLE_CYCLES = 1,
    parameter logic [COUNT_WIDTH-1:0] TIMEOUT       = '0,
    parameter logic [GPIO_WIDTH-1:0]  GPIO_INIT     = '0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [GPIO_WIDTH-1:0]  gpio_pin_out,
    output logic [GPIO_WIDTH-1:0]  gpio_pin_in,
    output logic                   dut_resetn,
    output logic [COUNT_WIDTH-1:0] cycle_count,
    output logic                   done,
    output logic [1:0]             status,
    output logic [COUNT_WIDTH-1:0] result_cycles
);

    localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;
    localparam int MW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;

    localparam logic [HW-1:0]          HOLD_LAST    = HW'(RESET_CYCLES - 1);
    localparam logic [MW-1:0]          MATCH_TARGET = MW'(STABLE_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT - COUNT_WIDTH'(1);

    localparam logic [1:0] ST_RUNNING = 2'b00;
    localparam logic [1:0] ST_PASS    = 2'b01;
    localparam logic [1:0] ST_FAIL    = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;

    state_t                 state;
    logic [HW-1:0]          hold_cnt;
    logic [MW-1:0]          match_cnt;
    logic                   last_pass;   // code class of the previous matching sample
    logic [COUNT_WIDTH-1:0] run_start;

    logic                   is_pass;
    logic                   is_fail;
    logic                   is_code;
    logic                   same_code;
    logic [MW-1:0]          match_nxt;
    logic [COUNT_WIDTH-1:0] start_nxt;
    logic                   match_hit;
    logic                   timeout_hit;

    // The DUT GPIO input is a constant stimulus
    assign gpio_pin_in = GPIO_INIT;

    // Classify the current sample and work out the next stability-run state
    always_comb begin
        is_pass   = (gpio_pin_out == PASS_CODE);
        is_fail   = (gpio_pin_out == FAIL_CODE);
        is_code   = is_pass | is_fail;
        // A run continues only if the previous sample was the same code
        same_code = is_code && (match_cnt != '0) && (last_pass == is_pass);
        match_nxt = '0;
        start_nxt = run_start;
        if (is_code) begin
            if (same_code) begin
                match_nxt = match_cnt + MW'(1);
            end else begin
                match_nxt = MW'(1);
                start_nxt = cycle_count;
            end
        end
        match_hit   = is_code && (match_nxt == MATCH_TARGET);
        timeout_hit = (TIMEOUT != '0) && (cycle_count == TIMEOUT_LAST);
    end

    // Main HOLD -> RUN -> DONE sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= HOLD;
            hold_cnt      <= '0;
            dut_resetn    <= 1'b0;
            cycle_count   <= '0;
            match_cnt     <= '0;
            last_pass     <= 1'b0;
            run_start     <= '0;
            result_cycles <= '0;
            done          <= 1'b0;
            status        <= ST_RUNNING;
        end else begin
            case (state)
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state       <= RUN;
                        dut_resetn  <= 1'b1;
                        cycle_count <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                RUN: begin
                    // Saturate rather than wrap so a stuck test never looks young
                    if (!(&cycle_count)) cycle_count <= cycle_count + COUNT_WIDTH'(1);
                    match_cnt <= match_nxt;
                    last_pass <= is_pass;
                    run_start <= start_nxt;
                    // A completing code beats a coincident timeout
                    if (match_hit) begin
                        state         <= DONE;
                        done          <= 1'b1;
                        status        <= is_pass ? ST_PASS : ST_FAIL;
                        result_cycles <= start_nxt;
                    end else if (timeout_hit) begin
                        state         <= DONE;
                        done          <= 1'b1;
                        status        <= ST_TIMEOUT;
                        result_cycles <= TIMEOUT;
                    end
                end
                DONE: begin
                    // Verdict frozen until resetn restarts the sequence
                end
                default: state <= HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_test_monitor.sv
// Directed bench for gpio_test_monitor: several parameterisations share
// one clock and resetn, each with its own GPIO stimulus.
module tb_gpio_test_monitor;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // u0: defaults
    logic [7:0]  g0;
    logic [7:0]  gi0;
    logic        dr0, dn0;
    logic [63:0] cc0, rc0;
    logic [1:0]  st0;
    // u3: STABLE_CYCLES=3
    logic [7:0]  g3;
    logic [7:0]  gi3;
    logic        dr3, dn3;
    logic [63:0] cc3, rc3;
    logic [1:0]  st3;
    // u4: TIMEOUT=50
    logic [7:0]  g4;
    logic [7:0]  gi4;
    logic        dr4, dn4;
    logic [63:0] cc4, rc4;
    logic [1:0]  st4;
    // u6: 16-bit GPIO, 4-bit counter
    logic [15:0] g6;
    logic [15:0] gi6;
    logic        dr6, dn6;
    logic [3:0]  cc6, rc6;
    logic [1:0]  st6;

    gpio_test_monitor u0 (
        .clk(clk), .resetn(resetn), .gpio_pin_out(g0), .gpio_pin_in(gi0),
        .dut_resetn(dr0), .cycle_count(cc0), .done(dn0), .status(st0), .result_cycles(rc0));

    gpio_test_monitor #(.STABLE_CYCLES(3)) u3 (
        .clk(clk), .resetn(resetn), .gpio_pin_out(g3), .gpio_pin_in(gi3),
        .dut_resetn(dr3), .cycle_count(cc3), .done(dn3), .status(st3), .result_cycles(rc3));

    gpio_test_monitor #(.TIMEOUT(64'd50)) u4 (
        .clk(clk), .resetn(resetn), .gpio_pin_out(g4), .gpio_pin_in(gi4),
        .dut_resetn(dr4), .cycle_count(cc4), .done(dn4), .status(st4), .result_cycles(rc4));

    gpio_test_monitor #(.GPIO_WIDTH(16), .COUNT_WIDTH(4)) u6 (
        .clk(clk), .resetn(resetn), .gpio_pin_out(g6), .gpio_pin_in(gi6),
        .dut_resetn(dr6), .cycle_count(cc6), .done(dn6), .status(st6), .result_cycles(rc6));

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset all instances and leave them in RUN with cycle_count == 0
    task automatic apply_reset();
        g0 = 8'h55; g3 = 8'h55; g4 = 8'h55; g6 = 16'h5555;
        resetn = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        g0 = 8'h55; g3 = 8'h55; g4 = 8'h55; g6 = 16'h5555;
        resetn = 1'b0;
        repeat (3) step();
        n_checks++; if (dr0 !== 1'b0) begin n_fail++; $display("FAIL reset_dut_resetn got %b want 0", dr0); end
        n_checks++; if (cc0 !== 64'd0) begin n_fail++; $display("FAIL reset_cycle_count got %0d want 0", cc0); end
        n_checks++; if (dn0 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", dn0); end
        n_checks++; if (st0 !== 2'b00) begin n_fail++; $display("FAIL reset_status got %b want 00", st0); end
        n_checks++; if (rc0 !== 64'd0) begin n_fail++; $display("FAIL reset_result got %0d want 0", rc0); end
        n_checks++; if (gi0 !== 8'h00) begin n_fail++; $display("FAIL reset_gpio_in got %h want 00", gi0); end
        resetn = 1'b1;
        step();
        n_checks++; if (dr0 !== 1'b0) begin n_fail++; $display("FAIL hold_cycle2_dut_resetn got %b want 0", dr0); end
        step();
        n_checks++; if (dr0 !== 1'b1) begin n_fail++; $display("FAIL run_entry_dut_resetn got %b want 1", dr0); end
        n_checks++; if (cc0 !== 64'd0) begin n_fail++; $display("FAIL run_entry_count got %0d want 0", cc0); end
        step();
        n_checks++; if (cc0 !== 64'd1) begin n_fail++; $display("FAIL run_count1 got %0d want 1", cc0); end
        step();
        n_checks++; if (cc0 !== 64'd2) begin n_fail++; $display("FAIL run_count2 got %0d want 2", cc0); end
    endtask

    task automatic test_pass();
        logic [63:0] frozen;
        apply_reset();
        repeat (10) step();
        n_checks++; if (dn0 !== 1'b0) begin n_fail++; $display("FAIL pass_not_early got %b want 0", dn0); end
        g0 = 8'hff;
        step();
        n_checks++; if (dn0 !== 1'b1) begin n_fail++; $display("FAIL pass_done got %b want 1", dn0); end
        n_checks++; if (st0 !== 2'b01) begin n_fail++; $display("FAIL pass_status got %b want 01", st0); end
        n_checks++; if (rc0 !== 64'd10) begin n_fail++; $display("FAIL pass_result got %0d want 10", rc0); end
        frozen = cc0;
        g0 = 8'h00;
        repeat (3) step();
        n_checks++; if (st0 !== 2'b01) begin n_fail++; $display("FAIL done_status_frozen got %b want 01", st0); end
        n_checks++; if (rc0 !== 64'd10) begin n_fail++; $display("FAIL done_result_frozen got %0d want 10", rc0); end
        n_checks++; if (cc0 !== frozen) begin n_fail++; $display("FAIL done_count_stopped got %0d want %0d", cc0, frozen); end
        n_checks++; if (dr0 !== 1'b1) begin n_fail++; $display("FAIL done_dut_resetn got %b want 1", dr0); end
    endtask

    task automatic test_stable();
        apply_reset();
        // ff glitch at 5,6; 55 at 7..19; ff held from 20
        for (int k = 0; k <= 22; k++) begin
            if (k == 5 || k == 6 || k >= 20) g3 = 8'hff;
            else g3 = 8'h55;
            if (k == 8) begin
                n_checks++; if (dn3 !== 1'b0) begin n_fail++; $display("FAIL stable_glitch_ignored got %b want 0", dn3); end
            end
            if (k == 22) begin
                n_checks++; if (dn3 !== 1'b0) begin n_fail++; $display("FAIL stable_not_early got %b want 0", dn3); end
            end
            step();
        end
        n_checks++; if (dn3 !== 1'b1) begin n_fail++; $display("FAIL stable_done got %b want 1", dn3); end
        n_checks++; if (st3 !== 2'b01) begin n_fail++; $display("FAIL stable_status got %b want 01", st3); end
        n_checks++; if (rc3 !== 64'd20) begin n_fail++; $display("FAIL stable_result got %0d want 20", rc3); end
        // PASS at 3,4 then FAIL from 5: stability restarts on the new code
        apply_reset();
        for (int k = 0; k <= 7; k++) begin
            if (k == 3 || k == 4) g3 = 8'hff;
            else if (k >= 5) g3 = 8'h00;
            else g3 = 8'h55;
            step();
        end
        n_checks++; if (dn3 !== 1'b1) begin n_fail++; $display("FAIL switch_done got %b want 1", dn3); end
        n_checks++; if (st3 !== 2'b10) begin n_fail++; $display("FAIL switch_status got %b want 10", st3); end
        n_checks++; if (rc3 !== 64'd5) begin n_fail++; $display("FAIL switch_result got %0d want 5", rc3); end
    endtask

    task automatic test_timeout();
        apply_reset();
        repeat (49) step();
        n_checks++; if (dn4 !== 1'b0) begin n_fail++; $display("FAIL timeout_not_early got %b want 0", dn4); end
        step();
        n_checks++; if (dn4 !== 1'b1) begin n_fail++; $display("FAIL timeout_done got %b want 1", dn4); end
        n_checks++; if (st4 !== 2'b11) begin n_fail++; $display("FAIL timeout_status got %b want 11", st4); end
        n_checks++; if (rc4 !== 64'd50) begin n_fail++; $display("FAIL timeout_result got %0d want 50", rc4); end
        apply_reset();
        repeat (49) step();
        g4 = 8'hff;
        step();
        n_checks++; if (st4 !== 2'b01) begin n_fail++; $display("FAIL coincident_status got %b want 01", st4); end
        n_checks++; if (rc4 !== 64'd49) begin n_fail++; $display("FAIL coincident_result got %0d want 49", rc4); end
    endtask

    task automatic test_fail_restart();
        apply_reset();
        repeat (7) step();
        g0 = 8'h00;
        step();
        n_checks++; if (dn0 !== 1'b1) begin n_fail++; $display("FAIL fail_done got %b want 1", dn0); end
        n_checks++; if (st0 !== 2'b10) begin n_fail++; $display("FAIL fail_status got %b want 10", st0); end
        n_checks++; if (rc0 !== 64'd7) begin n_fail++; $display("FAIL fail_result got %0d want 7", rc0); end
        g0 = 8'h55;
        resetn = 1'b0;
        step();
        n_checks++; if (dn0 !== 1'b0) begin n_fail++; $display("FAIL restart_done got %b want 0", dn0); end
        n_checks++; if (st0 !== 2'b00) begin n_fail++; $display("FAIL restart_status got %b want 00", st0); end
        n_checks++; if (rc0 !== 64'd0) begin n_fail++; $display("FAIL restart_result got %0d want 0", rc0); end
        n_checks++; if (cc0 !== 64'd0) begin n_fail++; $display("FAIL restart_count got %0d want 0", cc0); end
        n_checks++; if (dr0 !== 1'b0) begin n_fail++; $display("FAIL restart_dut_resetn got %b want 0", dr0); end
        resetn = 1'b1;
        step();
        n_checks++; if (dr0 !== 1'b0) begin n_fail++; $display("FAIL restart_hold got %b want 0", dr0); end
        step();
        n_checks++; if (dr0 !== 1'b1) begin n_fail++; $display("FAIL restart_run got %b want 1", dr0); end
    endtask

    task automatic test_saturate();
        apply_reset();
        repeat (3) step();
        // Partial matches of the 16-bit codes must not count
        g6 = 16'h00ff;
        step();
        g6 = 16'hff00;
        step();
        g6 = 16'h5555;
        n_checks++; if (dn6 !== 1'b0) begin n_fail++; $display("FAIL wide_partial_ignored got %b want 0", dn6); end
        repeat (10) step();
        n_checks++; if (cc6 !== 4'd15) begin n_fail++; $display("FAIL sat_reach got %0d want 15", cc6); end
        repeat (5) step();
        n_checks++; if (cc6 !== 4'd15) begin n_fail++; $display("FAIL sat_no_wrap got %0d want 15", cc6); end
        n_checks++; if (dn6 !== 1'b0) begin n_fail++; $display("FAIL sat_not_done got %b want 0", dn6); end
        g6 = 16'hffff;
        step();
        n_checks++; if (dn6 !== 1'b1) begin n_fail++; $display("FAIL sat_pass_done got %b want 1", dn6); end
        n_checks++; if (st6 !== 2'b01) begin n_fail++; $display("FAIL sat_pass_status got %b want 01", st6); end
        n_checks++; if (rc6 !== 4'd15) begin n_fail++; $display("FAIL sat_pass_result got %0d want 15", rc6); end
    endtask

    initial begin
        g0 = 8'h55; g3 = 8'h55; g4 = 8'h55; g6 = 16'h5555;
        test_reset();
        test_pass();
        test_stable();
        test_timeout();
        test_fail_restart();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
